seg7_scan_ctrl: RTL and testbench

Scan controller that owns the 74HC595 shift-register chain driving the board's 4-digit 7-segment display. It holds a 16-bit hex value plus decimal points, multiplexes the digits one at a time, serialises each digit's 16-bit frame onto the serial pins and latches it. It sits inside system_top, between the CPU-side register interface and the STCP/SHCP/DS/OE pins.

---
 rtl/seg7_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display driven through a 74HC595 chain.
// It multiplexes the digits one at a time, shifts each 16-bit frame out MSB first and latches it.
module seg7_scan_ctrl #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned DIGIT_HOLD = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_data,
    input  logic [3:0]  i_dots,
    input  logic        i_we,
    input  logic        i_blank,
    output logic        o_stcp,
    output logic        o_shcp,
    output logic        o_ds,
    output logic        o_oe,
    output logic        o_frame_done
);

    localparam int unsigned BIT_CYC = 2 * CLK_DIV;
    localparam int unsigned CNT_MAX = (BIT_CYC > DIGIT_HOLD) ? BIT_CYC : DIGIT_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] SHCP_HI    = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(DIGIT_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        RESET_IDLE,
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } state_t;

    typedef struct packed {
        logic [3:0]  dots;
        logic [15:0] data;
    } disp_t;

    state_t            r_state, w_state_nxt;
    disp_t             r_shadow;
    disp_t             r_active, w_active_nxt;
    logic [1:0]        r_digit, w_digit_nxt;
    logic [3:0]        r_bit, w_bit_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [15:0]       r_shift, w_shift_nxt;
    logic              r_first, w_first_nxt;
    logic              r_stcp, w_stcp_nxt;
    logic              r_shcp, w_shcp_nxt;
    logic              r_ds, w_ds_nxt;
    logic              r_oe, w_oe_nxt;
    logic              r_frame_done, w_frame_done_nxt;
    logic [3:0]        w_nib;
    logic              w_dp;

    // Hex nibble to active-high gfedcba pattern.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // CPU-side shadow; the last write before a digit-0 LOAD is what the next scan shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (i_we) begin
            r_shadow <= '{dots: i_dots, data: i_data};
        end
    end

    // Next-state, datapath and pin values; pins are registered from the next-state view.
    always_comb begin
        w_state_nxt      = r_state;
        w_active_nxt     = r_active;
        w_digit_nxt      = r_digit;
        w_bit_nxt        = r_bit;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_first_nxt      = r_first;
        w_frame_done_nxt = 1'b0;
        w_nib            = 4'h0;
        w_dp             = 1'b0;

        case (r_state)
            RESET_IDLE: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                if (r_digit == 2'd0) begin
                    w_active_nxt = r_shadow;
                end
                w_nib       = w_active_nxt.data[{r_digit, 2'b00} +: 4];
                w_dp        = w_active_nxt.dots[r_digit];
                w_shift_nxt = {~{w_dp, hex_seg(w_nib)}, 4'b0000, 4'b0001 << r_digit};
                w_bit_nxt   = 4'd0;
                w_cnt_nxt   = '0;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_shift[14:0], 1'b0};
                    w_bit_nxt   = r_bit + 4'd1;
                    if (r_bit == 4'd15) begin
                        w_state_nxt = LATCH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            LATCH: begin
                if (r_cnt == LATCH_LAST) begin
                    w_cnt_nxt        = '0;
                    w_frame_done_nxt = 1'b1;
                    w_first_nxt      = 1'b1;
                    w_state_nxt      = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_digit_nxt = r_digit + 2'd1;
                    w_state_nxt = LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = RESET_IDLE;
            end
        endcase

        w_stcp_nxt = (w_state_nxt == LATCH);
        w_shcp_nxt = (w_state_nxt == SHIFT) && (w_cnt_nxt >= SHCP_HI);
        w_ds_nxt   = w_shift_nxt[15];
        w_oe_nxt   = i_blank | ~r_first;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RESET_IDLE;
            r_active     <= '0;
            r_digit      <= 2'd0;
            r_bit        <= 4'd0;
            r_cnt        <= '0;
            r_shift      <= 16'h0000;
            r_first      <= 1'b0;
            r_stcp       <= 1'b0;
            r_shcp       <= 1'b0;
            r_ds         <= 1'b0;
            r_oe         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_active     <= w_active_nxt;
            r_digit      <= w_digit_nxt;
            r_bit        <= w_bit_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_first      <= w_first_nxt;
            r_stcp       <= w_stcp_nxt;
            r_shcp       <= w_shcp_nxt;
            r_ds         <= w_ds_nxt;
            r_oe         <= w_oe_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign o_stcp       = r_stcp;
    assign o_shcp       = r_shcp;
    assign o_ds         = r_ds;
    assign o_oe         = r_oe;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: frames are decoded off the serial pins and
// compared with a digit/scan model; a second fast instance checks period and pin protocol.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_data;
    logic [3:0]  i_dots;
    logic        i_we;
    logic        i_blank;
    logic        o_stcp, o_shcp, o_ds, o_oe, o_frame_done;
    logic        f_stcp, f_shcp, f_ds, f_oe, f_frame_done;

    seg7_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_dots(i_dots), .i_we(i_we),
        .i_blank(i_blank), .o_stcp(o_stcp), .o_shcp(o_shcp), .o_ds(o_ds), .o_oe(o_oe),
        .o_frame_done(o_frame_done)
    );

    seg7_scan_ctrl #(.CLK_DIV(1), .DIGIT_HOLD(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .i_data(16'h0000), .i_dots(4'h0), .i_we(1'b0),
        .i_blank(1'b0), .o_stcp(f_stcp), .o_shcp(f_shcp), .o_ds(f_ds), .o_oe(f_oe),
        .o_frame_done(f_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Active-high gfedcba per hex digit.
    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [15:0] model_frame(input logic [15:0] val, input logic [3:0] dots,
                                                input int k);
        logic [3:0] nib;
        logic [3:0] oh;
        logic [7:0] lit;
        nib = 4'((val >> (4 * k)) & 16'h000F);
        oh  = 4'(1 << k);
        lit = {dots[k], seg_tbl[nib]};
        return {~lit, 4'h0, oh};
    endfunction

    // Pin decoder for the main instance.
    logic [15:0] q_frames[$];
    int          q_nbits[$];
    logic [15:0] acc;
    int          nbits;
    logic        p_shcp, p_stcp, p_ds, p_fd;
    int          viol_ovl = 0, viol_ds = 0, viol_fd = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc    <= 16'h0;
            nbits  <= 0;
            p_shcp <= 1'b0;
            p_stcp <= 1'b0;
            p_ds   <= 1'b0;
            p_fd   <= 1'b0;
        end else begin
            if (o_shcp && o_stcp) viol_ovl <= viol_ovl + 1;
            if ((o_ds !== p_ds) && o_shcp) viol_ds <= viol_ds + 1;
            if (o_frame_done && p_fd) viol_fd <= viol_fd + 1;
            if (o_shcp && !p_shcp) begin
                acc   <= {acc[14:0], o_ds};
                nbits <= nbits + 1;
            end
            if (o_stcp && !p_stcp) begin
                q_frames.push_back(acc);
                q_nbits.push_back(nbits);
                nbits <= 0;
            end
            p_shcp <= o_shcp;
            p_stcp <= o_stcp;
            p_ds   <= o_ds;
            p_fd   <= o_frame_done;
        end
    end

    // Period and protocol watcher for the fast instance.
    int   f_cyc = 0, f_last = 0, f_cnt = 0, f_bad = 0, f_ovl = 0, f_dsv = 0;
    logic f_valid = 1'b0;
    logic fp_ds = 1'b0;

    always @(negedge clk) begin
        f_cyc <= f_cyc + 1;
        if (!rst_n) begin
            f_valid <= 1'b0;
            fp_ds   <= 1'b0;
        end else begin
            if (f_shcp && f_stcp) f_ovl <= f_ovl + 1;
            if ((f_ds !== fp_ds) && f_shcp) f_dsv <= f_dsv + 1;
            fp_ds <= f_ds;
            if (f_frame_done) begin
                if (f_valid) begin
                    f_cnt <= f_cnt + 1;
                    if (f_cyc - f_last != 35) f_bad <= f_bad + 1;
                end
                f_last  <= f_cyc;
                f_valid <= 1'b1;
            end
        end
    end

    // Display model: shadow written by the CPU, captured into the scan at each digit 0.
    logic [15:0] m_sh_d, m_act_d;
    logic [3:0]  m_sh_p, m_act_p;
    int          m_digit;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_sh_d = 16'h0; m_sh_p = 4'h0; m_act_d = 16'h0; m_act_p = 4'h0; m_digit = 0;
        q_frames.delete();
        q_nbits.delete();
    endtask

    task automatic do_write(input logic [15:0] d, input logic [3:0] p);
        i_data = d; i_dots = p; i_we = 1'b1;
        tick();
        i_we = 1'b0;
        m_sh_d = d; m_sh_p = p;
    endtask

    task automatic expect_frames(input int n);
        for (int i = 0; i < n; i++) begin
            int budget = 0;
            while (q_frames.size() == 0 && budget < 1200) begin
                tick();
                budget++;
            end
            if (q_frames.size() == 0) begin
                check("frame_timeout", 32'd0, 32'd1);
            end else begin
                logic [15:0] f;
                int nb;
                f  = q_frames.pop_front();
                nb = q_nbits.pop_front();
                if (m_digit == 0) begin
                    m_act_d = m_sh_d;
                    m_act_p = m_sh_p;
                end
                check("frame", 32'(f), 32'(model_frame(m_act_d, m_act_p, m_digit)));
                check("shcp_rises", 32'(nb), 32'd16);
                m_digit = (m_digit + 1) % 4;
            end
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_stcp"}, 32'(o_stcp), 32'd0);
        check({tag, "_shcp"}, 32'(o_shcp), 32'd0);
        check({tag, "_ds"}, 32'(o_ds), 32'd0);
        check({tag, "_oe"}, 32'(o_oe), 32'd1);
        check({tag, "_fd"}, 32'(o_frame_done), 32'd0);
    endtask

    // Release reset, measure first STCP rise, then confirm the display enables after that latch.
    task automatic release_and_first_frame(input string tag);
        int n;
        logic seen;
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            seen = o_stcp;
        end
        check({tag, "_stcp_latency"}, 32'(n), 32'd66);
        check({tag, "_oe_in_latch"}, 32'(o_oe), 32'd1);
        expect_frames(1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = o_frame_done;
            if (!seen) tick();
        end
        check({tag, "_frame_done"}, 32'(seen), 32'd1);
        repeat (3) tick();
        check({tag, "_oe_enabled"}, 32'(o_oe), 32'd0);
    endtask

    logic [15:0] v_load;
    logic [3:0]  p_load;

    initial begin
        rst_n = 1'b0; i_data = 16'h0; i_dots = 4'h0; i_we = 1'b0; i_blank = 1'b0;
        model_reset();
        repeat (3) tick();
        check_reset_pins("reset");
        check("fast_reset_oe", 32'(f_oe), 32'd1);

        release_and_first_frame("boot");

        // Write in digit-0 hold: rest of this scan stays old, the next scan shows it.
        do_write(16'h1234, 4'b0001);
        expect_frames(7);

        // Write landing in the LOAD cycle of digit 0 is not picked up by that scan.
        v_load = 16'($urandom);
        p_load = 4'($urandom);
        repeat (1002) tick();
        i_data = v_load; i_dots = p_load; i_we = 1'b1;
        tick();
        i_we = 1'b0;
        expect_frames(1);
        m_sh_d = v_load; m_sh_p = p_load;
        expect_frames(3);

        // Write in the middle of digit 2 SHIFT does not tear the current scan.
        expect_frames(2);
        repeat (1033) tick();
        do_write(16'hABCD, 4'($urandom));
        expect_frames(6);

        // Blanking forces OE high next cycle without disturbing the shift stream.
        repeat (10) tick();
        i_blank = 1'b1;
        tick();
        check("blank_oe_on", 32'(o_oe), 32'd1);
        expect_frames(1);
        check("blank_oe_held", 32'(o_oe), 32'd1);
        i_blank = 1'b0;
        tick();
        check("blank_oe_off", 32'(o_oe), 32'd0);

        // Random writes during digit-0 hold, back-to-back so the last one must win.
        for (int it = 0; it < 2; it++) begin
            repeat ($urandom_range(3, 900)) tick();
            do_write(16'($urandom), 4'($urandom));
            do_write(16'($urandom), 4'($urandom));
            expect_frames(4);
        end

        // Async reset in bit 7 of SHIFT returns pins immediately and restarts at digit 0.
        repeat (1032) tick();
        rst_n = 1'b0;
        #1;
        check_reset_pins("midreset");
        tick();
        model_reset();
        release_and_first_frame("reboot");
        expect_frames(3);

        check("no_shcp_stcp_overlap", 32'(viol_ovl), 32'd0);
        check("ds_stable_shcp_high", 32'(viol_ds), 32'd0);
        check("frame_done_one_cycle", 32'(viol_fd), 32'd0);
        check("fast_no_overlap", 32'(f_ovl), 32'd0);
        check("fast_ds_stable", 32'(f_dsv), 32'd0);
        check("fast_period_35", 32'(f_bad), 32'd0);
        check("fast_pulse_count", 32'(f_cnt >= 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
